// File: rtl/float_alu_if.sv
// Operand/result handshake bundle for float_alu: operand pair in, one result out.
interface float_alu_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        ovf;
    logic        unf;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, ovf, unf
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, ovf, unf
    );
endinterface

// File: rtl/float_alu.sv
// Multicycle 16-bit floatType ADD/MULT stage, one operation in flight at a time.
// Sequence: accept -> ALIGN -> OP -> NORM (one shift per cycle) -> DONE.
module float_alu (
    input  logic        clk,
    input  logic        rst_n,
    float_alu_if.slave  bus
);
    localparam int unsigned MW  = 10;
    localparam int unsigned EW  = 5;
    localparam int unsigned IEW = 7;
    localparam int unsigned PW  = 2 * MW;
    localparam int unsigned SW  = MW + 1;

    localparam logic signed [IEW-1:0] EXP_MAX = 7'sd15;
    localparam logic signed [IEW-1:0] EXP_MIN = -7'sd16;
    localparam logic signed [IEW-1:0] EXP_ONE = 7'sd1;

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [MW-1:0] mant;
    } float_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_OP,
        S_NORM,
        S_DONE
    } state_t;

    state_t                 state_q;
    float_t                 a_q, b_q;
    logic                   op_q;
    logic                   sign_q, sign_s_q;
    logic signed [IEW-1:0]  exp_q;
    logic [MW-1:0]          mant_q, mant_s_q;
    logic                   in_ready_q, out_valid_q, ovf_q, unf_q;
    logic [15:0]            result_q;

    float_t                 l_d, s_d;
    logic signed [IEW-1:0]  ea_d, eb_d, el_d, es_d;
    logic [IEW-1:0]         shift_d;
    logic                   a_zero_d, b_zero_d, a_is_l_d;
    logic [MW-1:0]          mant_s_d;
    logic [PW-1:0]          prod_d;
    logic signed [IEW-1:0]  mul_exp_d, add_exp_d;
    logic [MW-1:0]          mul_mant_d, add_mant_d;
    logic [SW-1:0]          sum_d;
    logic [15:0]            result_d;
    logic                   ovf_d, unf_d;

    // ALIGN: pick larger magnitude as L (a zero word never wins), align S to it
    always_comb begin
        ea_d     = {{(IEW-EW){a_q.exp[EW-1]}}, a_q.exp};
        eb_d     = {{(IEW-EW){b_q.exp[EW-1]}}, b_q.exp};
        a_zero_d = (a_q.mant == '0);
        b_zero_d = (b_q.mant == '0);
        a_is_l_d = !a_zero_d &&
                   (b_zero_d || (ea_d > eb_d) || ((ea_d == eb_d) && (a_q.mant >= b_q.mant)));
        l_d      = a_is_l_d ? a_q  : b_q;
        s_d      = a_is_l_d ? b_q  : a_q;
        el_d     = a_is_l_d ? ea_d : eb_d;
        es_d     = a_is_l_d ? eb_d : ea_d;
        shift_d  = IEW'(el_d - es_d);
        if ((s_d.mant == '0) || (shift_d >= IEW'(SW))) begin
            mant_s_d = '0;
        end else begin
            mant_s_d = s_d.mant >> shift_d;
        end
    end

    // OP: product for MULT, signed-magnitude sum/difference for ADD
    always_comb begin
        prod_d    = PW'(a_q.mant) * PW'(b_q.mant);
        mul_exp_d = ea_d + eb_d;
        if (prod_d[PW-1]) begin
            mul_mant_d = prod_d[PW-1 -: MW];
        end else begin
            mul_mant_d = prod_d[PW-2 -: MW];
            mul_exp_d  = mul_exp_d - EXP_ONE;
        end

        sum_d      = SW'(mant_q) + SW'(mant_s_q);
        add_exp_d  = exp_q;
        add_mant_d = mant_q - mant_s_q;
        if (sign_q == sign_s_q) begin
            if (sum_d[MW]) begin
                add_mant_d = sum_d[MW:1];
                add_exp_d  = exp_q + EXP_ONE;
            end else begin
                add_mant_d = sum_d[MW-1:0];
            end
        end
    end

    // Final word with zero canonicalisation, saturation and flush
    always_comb begin
        result_d = {sign_q, exp_q[EW-1:0], mant_q};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (mant_q == '0) begin
            result_d = '0;
        end else if (exp_q > EXP_MAX) begin
            result_d = {sign_q, EXP_MAX[EW-1:0], {MW{1'b1}}};
            ovf_d    = 1'b1;
        end else if (exp_q < EXP_MIN) begin
            result_d = '0;
            unf_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            sign_q      <= 1'b0;
            sign_s_q    <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            mant_s_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        op_q       <= bus.op;
                        in_ready_q <= 1'b0;
                        state_q    <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    sign_q   <= l_d.sign;
                    sign_s_q <= s_d.sign;
                    exp_q    <= el_d;
                    mant_q   <= l_d.mant;
                    mant_s_q <= mant_s_d;
                    state_q  <= S_OP;
                end
                S_OP: begin
                    if (op_q) begin
                        sign_q <= a_q.sign ^ b_q.sign;
                        exp_q  <= mul_exp_d;
                        mant_q <= mul_mant_d;
                    end else begin
                        exp_q  <= add_exp_d;
                        mant_q <= add_mant_d;
                    end
                    state_q <= S_NORM;
                end
                S_NORM: begin
                    if ((mant_q != '0) && !mant_q[MW-1]) begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - EXP_ONE;
                    end else begin
                        result_q    <= result_d;
                        ovf_q       <= ovf_d;
                        unf_q       <= unf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
endmodule

// File: tb/tb_float_alu.sv
// Directed-vector bench for float_alu: latency, values, flags, backpressure, mid-op reset.
module tb_float_alu;
    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   failed;

    float_alu_if bus ();

    float_alu u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present an operand pair and let it be accepted on the next rising edge
    task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic op);
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
        bus.in_valid = 1'b1;
        chk({tag, ".in_ready"}, 16'(bus.in_ready), 16'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid and check latency, word and flags
    task automatic wait_result(input string tag, input logic [15:0] res, input logic ovf,
                               input logic unf, input int lat_exp);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, 16'(lat), 16'(lat_exp));
        chk({tag, ".result"}, bus.result, res);
        chk({tag, ".ovf"}, 16'(bus.ovf), 16'(ovf));
        chk({tag, ".unf"}, 16'(bus.unf), 16'(unf));
        chk({tag, ".busy"}, 16'(bus.in_ready), 16'd0);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 16'(bus.out_valid), 16'd0);
        chk({tag, ".ready_back"}, 16'(bus.in_ready), 16'd1);
    endtask

    initial begin
        bit seen_valid;
        total         = 0;
        passed        = 0;
        failed        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.in_ready", 16'(bus.in_ready), 16'd1);
        chk("rst.out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst.result", bus.result, 16'h0000);
        chk("rst.ovf", 16'(bus.ovf), 16'd0);
        chk("rst.unf", 16'(bus.unf), 16'd0);
        rst_n = 1'b1;

        // 1.5 x 1.5 = 2.25
        start_op("mul15", 16'h0700, 16'h0700, 1'b1);
        wait_result("mul15", 16'h0A40, 1'b0, 1'b0, 3);
        release_result("mul15");

        // 1.0 + (-0.75) = 0.25, two normalise shifts
        start_op("add_sub", 16'h0600, 16'h8300, 1'b0);
        wait_result("add_sub", 16'h7E00, 1'b0, 1'b0, 5);
        release_result("add_sub");

        // exact cancellation
        start_op("cancel", 16'h0600, 16'h8600, 1'b0);
        wait_result("cancel", 16'h0000, 1'b0, 1'b0, 3);
        release_result("cancel");

        // MULT by a zero word
        start_op("mul_zero", 16'h0700, 16'h0400, 1'b1);
        wait_result("mul_zero", 16'h0000, 1'b0, 1'b0, 3);
        release_result("mul_zero");

        start_op("mul_ovf", 16'h3E00, 16'h3E00, 1'b1);
        wait_result("mul_ovf", 16'h3FFF, 1'b1, 1'b0, 3);
        release_result("mul_ovf");

        start_op("mul_unf", 16'h4200, 16'h4200, 1'b1);
        wait_result("mul_unf", 16'h0000, 1'b0, 1'b1, 3);
        release_result("mul_unf");

        // 1.5 + 1.5 = 3.0, carry out of the sum
        start_op("add_carry", 16'h0700, 16'h0700, 1'b0);
        wait_result("add_carry", 16'h0B00, 1'b0, 1'b0, 3);
        release_result("add_carry");

        // zero A passes B through untouched
        start_op("add_zero", 16'h0000, 16'h8300, 1'b0);
        wait_result("add_zero", 16'h8300, 1'b0, 1'b0, 3);
        release_result("add_zero");

        // exponent gap of 15: small operand shifts out completely
        start_op("add_gap", 16'h3E00, 16'h03FF, 1'b0);
        wait_result("add_gap", 16'h3E00, 1'b0, 1'b0, 3);
        release_result("add_gap");

        start_op("add_ovf", 16'h3E00, 16'h3E00, 1'b0);
        wait_result("add_ovf", 16'h3FFF, 1'b1, 1'b0, 3);
        release_result("add_ovf");

        // 1.0 - 0.96875 = 1/32, five normalise shifts
        start_op("add_k5", 16'h0600, 16'h83E0, 1'b0);
        wait_result("add_k5", 16'h7200, 1'b0, 1'b0, 8);
        release_result("add_k5");

        // backpressure: hold the result for 10 cycles
        start_op("bp", 16'h0700, 16'h0700, 1'b1);
        wait_result("bp", 16'h0A40, 1'b0, 1'b0, 3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp.hold_valid", 16'(bus.out_valid), 16'd1);
            chk("bp.hold_result", bus.result, 16'h0A40);
            chk("bp.hold_busy", 16'(bus.in_ready), 16'd0);
        end
        release_result("bp");
        start_op("b2b", 16'h0600, 16'h8300, 1'b0);
        wait_result("b2b", 16'h7E00, 1'b0, 1'b0, 5);
        release_result("b2b");

        // reset while NORM is shifting a k=5 ADD
        start_op("rst_mid", 16'h0600, 16'h83E0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.in_ready", 16'(bus.in_ready), 16'd1);
        chk("rst_mid.out_valid", 16'(bus.out_valid), 16'd0);
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen_valid = 1'b1;
        end
        chk("rst_mid.no_valid", 16'(seen_valid), 16'd0);
        chk("rst_mid.idle", 16'(bus.in_ready), 16'd1);
        start_op("post_rst", 16'h0700, 16'h0700, 1'b1);
        wait_result("post_rst", 16'h0A40, 1'b0, 1'b0, 3);
        release_result("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
